// File: rtl/imm_ext_arbiter.sv
// Round-robin arbiter that shares one immediate extract/extend datapath between two requesters.
// Define IMM_BRANCH_SHIFT_EN to return branch formats (010/011) as byte offsets (<< 2).
module imm_ext_arbiter #(
    parameter int unsigned XLEN      = 64,
    parameter bit          RST_PRI_A = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [31:0]     a_instr,
    input  logic [2:0]      a_fmt,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [31:0]     b_instr,
    input  logic [2:0]      b_fmt,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic            out_src,
    output logic            out_illegal
);

    // last_grant_q: 0 = A was last served, 1 = B was last served
    logic            last_grant_q;
    logic            accept;
    logic            grant_a;
    logic            grant_b;
    logic            xfer;
    logic [31:0]     sel_instr;
    logic [2:0]      sel_fmt;
    logic [XLEN-1:0] imm_d;
    logic [XLEN-1:0] branch_ext;
    logic            illegal_d;
    logic            unused_instr_hi;

    // Bits [31:26] never belong to any immediate field.
    assign unused_instr_hi = ^{a_instr[31:26], b_instr[31:26]};

    always_comb begin
        accept  = ~out_valid | out_ready;
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (accept) begin
            if (a_valid && b_valid) begin
                grant_a = last_grant_q;
                grant_b = ~last_grant_q;
            end else begin
                grant_a = a_valid;
                grant_b = b_valid;
            end
        end
    end

    assign a_ready   = grant_a;
    assign b_ready   = grant_b;
    assign xfer      = grant_a | grant_b;
    assign sel_instr = grant_b ? b_instr : a_instr;
    assign sel_fmt   = grant_b ? b_fmt : a_fmt;

    always_comb begin
        imm_d      = '0;
        illegal_d  = 1'b0;
        branch_ext = '0;
        unique case (sel_fmt)
            3'b000: imm_d = {{(XLEN-12){1'b0}}, sel_instr[21:10]};
            3'b001: imm_d = {{(XLEN-9){sel_instr[20]}}, sel_instr[20:12]};
            3'b010: begin
                branch_ext = {{(XLEN-26){sel_instr[25]}}, sel_instr[25:0]};
`ifdef IMM_BRANCH_SHIFT_EN
                imm_d = {branch_ext[XLEN-3:0], 2'b00};
`else
                imm_d = branch_ext;
`endif
            end
            3'b011: begin
                branch_ext = {{(XLEN-19){sel_instr[23]}}, sel_instr[23:5]};
`ifdef IMM_BRANCH_SHIFT_EN
                imm_d = {branch_ext[XLEN-3:0], 2'b00};
`else
                imm_d = branch_ext;
`endif
            end
            3'b100: imm_d = {{(XLEN-16){1'b0}}, sel_instr[20:5]};
            default: illegal_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid    <= 1'b0;
            out_imm      <= '0;
            out_src      <= 1'b0;
            out_illegal  <= 1'b0;
            last_grant_q <= RST_PRI_A;
        end else if (xfer) begin
            out_valid    <= 1'b1;
            out_imm      <= imm_d;
            out_src      <= grant_b;
            out_illegal  <= illegal_d;
            last_grant_q <= grant_b;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Self-checking bench for imm_ext_arbiter: directed scenarios followed by randomized traffic,
// compared against an arithmetic reference model of the extraction and arbitration rules.
module tb_imm_ext_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_ready, b_valid, b_ready;
    logic [31:0] a_instr, b_instr;
    logic [2:0]  a_fmt, b_fmt;
    logic        out_valid, out_ready, out_src, out_illegal;
    logic [63:0] out_imm;

    int tests = 0;
    int fails = 0;

    // Model state: m_last 0 = A last served, 1 = B last served
    bit          m_valid, m_src, m_ill, m_last;
    logic [63:0] m_imm;

    imm_ext_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_instr    (a_instr),
        .a_fmt      (a_fmt),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_instr    (b_instr),
        .b_fmt      (b_fmt),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_imm    (out_imm),
        .out_src    (out_src),
        .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Field value from shift/mask, sign applied by subtracting 2^n, byte offset by multiply.
    function automatic logic [63:0] ref_imm(input logic [31:0] ins, input logic [2:0] f);
        int     lo, n;
        bit     sgn;
        longint v;
        case (f)
            3'd0: begin lo = 10; n = 12; sgn = 0; end
            3'd1: begin lo = 12; n = 9;  sgn = 1; end
            3'd2: begin lo = 0;  n = 26; sgn = 1; end
            3'd3: begin lo = 5;  n = 19; sgn = 1; end
            3'd4: begin lo = 5;  n = 16; sgn = 0; end
            default: return 64'd0;
        endcase
        v = longint'(ins >> lo) & ((longint'(1) << n) - 1);
        if (sgn && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
`ifdef IMM_BRANCH_SHIFT_EN
        if (f == 3'd2 || f == 3'd3) v = v * 4;
`endif
        return 64'(v);
    endfunction

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step(input string tag);
        bit acc, ga, gb;
        #1;
        acc = !m_valid || out_ready;
        ga  = acc && a_valid && (!b_valid || m_last);
        gb  = acc && b_valid && (!a_valid || !m_last);
        chk({tag, ":a_ready"}, 64'(a_ready), 64'(ga));
        chk({tag, ":b_ready"}, 64'(b_ready), 64'(gb));
        chk({tag, ":onehot"}, 64'(a_ready & b_ready), 64'd0);
        if (ga || gb) begin
            m_valid = 1'b1;
            m_src   = gb;
            m_imm   = gb ? ref_imm(b_instr, b_fmt) : ref_imm(a_instr, a_fmt);
            m_ill   = (gb ? b_fmt : a_fmt) >= 3'd5;
            m_last  = gb;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ":out_valid"}, 64'(out_valid), 64'(m_valid));
        if (m_valid) begin
            chk({tag, ":out_imm"}, out_imm, m_imm);
            chk({tag, ":out_src"}, 64'(out_src), 64'(m_src));
            chk({tag, ":out_illegal"}, 64'(out_illegal), 64'(m_ill));
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting at a negedge.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        chk({tag, ":rst_out_valid"}, 64'(out_valid), 64'd0);
        m_valid = 1'b0;
        m_last  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; b_valid = 0; a_instr = '0; b_instr = '0;
        a_fmt = '0; b_fmt = '0; out_ready = 0;
        m_valid = 0; m_src = 0; m_ill = 0; m_last = 1; m_imm = '0;
        repeat (2) @(negedge clk);
        chk("reset:out_valid", 64'(out_valid), 64'd0);
        chk("reset:out_imm", out_imm, 64'd0);
        chk("reset:out_src", 64'(out_src), 64'd0);
        chk("reset:out_illegal", 64'(out_illegal), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // A only, I format
        a_valid = 1; a_instr = 32'h9100_2C20; a_fmt = 3'b000; out_ready = 1;
        step("t1");
        chk("t1:imm_const", out_imm, 64'h00B);
        a_valid = 0;
        step("t1_drain");

        // Alternation under constant contention, starting from reset priority
        pulse_reset("t2");
        a_valid = 1; b_valid = 1; a_fmt = 3'b100; b_fmt = 3'b000;
        for (int i = 0; i < 4; i++) begin
            a_instr = $urandom; b_instr = $urandom;
            step("t2");
            chk("t2:src_seq", 64'(out_src), 64'(i % 2));
        end
        a_valid = 0; b_valid = 0;
        step("t2_drain");

        // B branch, all-ones field
        b_valid = 1; b_instr = 32'hA7FF_FFFF; b_fmt = 3'b010;
        step("t3");
`ifdef IMM_BRANCH_SHIFT_EN
        chk("t3:imm_const", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
`else
        chk("t3:imm_const", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
`endif
        chk("t3:src_const", 64'(out_src), 64'd1);
        b_valid = 0;

        // Backpressure hold then same-cycle acceptance
        a_valid = 1; a_instr = $urandom; a_fmt = 3'b100;
        step("t4_load");
        out_ready = 0; b_valid = 1; b_instr = $urandom; b_fmt = 3'b011;
        for (int i = 0; i < 3; i++) begin
            step("t4_hold");
            chk("t4:no_ready", 64'({a_ready, b_ready}), 64'd0);
        end
        out_ready = 1;
        step("t4_release");
        a_valid = 0; b_valid = 0;
        step("t4_drain");

        // Illegal format then negative D immediate
        a_valid = 1; a_instr = $urandom; a_fmt = 3'b110;
        step("t5_ill");
        chk("t5:ill_const", 64'(out_illegal), 64'd1);
        chk("t5:imm_zero", out_imm, 64'd0);
        a_instr = 32'h0010_0000; a_fmt = 3'b001;
        step("t5_d");
        chk("t5:d_const", out_imm, 64'hFFFF_FFFF_FFFF_FF00);

        // Reset while a result is pending and both request
        b_valid = 1; b_instr = $urandom; b_fmt = 3'b000; a_fmt = 3'b000;
        out_ready = 0;
        chk("t6:pending", 64'(out_valid), 64'd1);
        pulse_reset("t6");
        out_ready = 1;
        step("t6_after");
        chk("t6:a_first", 64'(out_src), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            a_valid   = ($urandom_range(0, 9) < 7);
            b_valid   = ($urandom_range(0, 9) < 7);
            a_instr   = $urandom;
            b_instr   = $urandom;
            a_fmt     = 3'($urandom_range(0, 7));
            b_fmt     = 3'($urandom_range(0, 7));
            out_ready = ($urandom_range(0, 9) < 7);
            step("rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
